// File: rtl/student_computer.sv
// Single-cycle Hack computer: 16-bit CPU with a combinational ROM fetch from a packed program
// image and a 32K-word RAM exposed as one packed vector.
module student_computer (
   input  logic            clk,
   input  logic            reset,
   // "program" is a reserved word in SystemVerilog, hence program_data
   input  logic [524287:0] program_data,
   input  logic [524287:0] memory,
   input  logic            reload,
   output logic [15:0]     ARegister,
   output logic [15:0]     DRegister,
   output logic [14:0]     pc,
   output logic [524287:0] mem_contents
);

   logic [15:0]     a_q;
   logic [15:0]     d_q;
   logic [14:0]     pc_q;
   logic [524287:0] ram_q;

   logic [15:0] instr;
   logic [15:0] m_val;
   logic        is_c;
   logic [15:0] alu_x, alu_y, alu_r, alu_out;
   logic        neg, zr, pos, take_jump;
   logic        dest_a, dest_d, dest_m;
   logic        unused_ok;

   assign instr = program_data[{pc_q, 4'b0000} +: 16];
   assign m_val = ram_q[{a_q[14:0], 4'b0000} +: 16];

   assign is_c   = instr[15];
   assign dest_a = is_c & instr[5];
   assign dest_d = is_c & instr[4];
   assign dest_m = is_c & instr[3];
   assign unused_ok = ^instr[14:13];

   always_comb begin
      alu_x = d_q;
      alu_y = instr[12] ? m_val : a_q;
      if (instr[11]) alu_x = 16'h0000;
      if (instr[10]) alu_x = ~alu_x;
      if (instr[9])  alu_y = 16'h0000;
      if (instr[8])  alu_y = ~alu_y;
      alu_r   = instr[7] ? (alu_x + alu_y) : (alu_x & alu_y);
      alu_out = instr[6] ? ~alu_r : alu_r;
   end

   assign neg = alu_out[15];
   assign zr  = (alu_out == 16'h0000);
   assign pos = ~neg & ~zr;
   assign take_jump = is_c & ((instr[2] & neg) | (instr[1] & zr) | (instr[0] & pos));

   // Jump target and M address both come from A as it stood before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q  <= 16'h0000;
         d_q  <= 16'h0000;
         pc_q <= 15'd0;
      end else begin
         if (!is_c) begin
            a_q <= instr;
         end else if (dest_a) begin
            a_q <= alu_out;
         end
         if (dest_d) d_q <= alu_out;
         pc_q <= take_jump ? a_q[14:0] : pc_q + 15'd1;
      end
   end

   // RAM has no reset; reload overrides any CPU store on the same edge.
   always_ff @(posedge clk) begin
      if (reload) begin
         ram_q <= memory;
      end else if (!reset && dest_m) begin
         ram_q[{a_q[14:0], 4'b0000} +: 16] <= alu_out;
      end
   end

   assign ARegister    = a_q;
   assign DRegister    = d_q;
   assign pc           = pc_q;
   assign mem_contents = ram_q;

endmodule

// File: tb/tb_student_computer.sv
// Scoreboard bench for student_computer: expectations are queued with the stimulus and
// compared against the DUT outputs once the instructions have executed.
module tb_student_computer;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            reload = 1'b0;
   logic [524287:0] prog = '0;
   logic [524287:0] mem = '0;
   logic [15:0]     areg, dreg;
   logic [14:0]     pc;
   logic [524287:0] mc;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      int          sel;
      int          addr;
      logic [15:0] exp;
   } exp_t;
   exp_t sb[$];

   localparam int SelA = 0, SelD = 1, SelPc = 2, SelRam = 3;

   logic [5:0] codes [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                              6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                              6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

   student_computer dut (
      .clk          (clk),
      .reset        (reset),
      .program_data (prog),
      .memory       (mem),
      .reload       (reload),
      .ARegister    (areg),
      .DRegister    (dreg),
      .pc           (pc),
      .mem_contents (mc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ram_word(input int i);
      return mc[16*i +: 16];
   endfunction

   function automatic logic [15:0] ci(input logic a, input logic [5:0] c, input logic [2:0] d,
                                      input logic [2:0] j);
      return {3'b111, a, c, d, j};
   endfunction

   // Reference Hack comp results, written as plain arithmetic on D and A.
   function automatic logic [15:0] ref_comp(input int k, input logic [15:0] d,
                                            input logic [15:0] a);
      case (k)
         0:  return 16'h0000;
         1:  return 16'h0001;
         2:  return 16'hFFFF;
         3:  return d;
         4:  return a;
         5:  return ~d;
         6:  return ~a;
         7:  return 16'h0000 - d;
         8:  return 16'h0000 - a;
         9:  return d + 16'h0001;
         10: return a + 16'h0001;
         11: return d - 16'h0001;
         12: return a - 16'h0001;
         13: return d + a;
         14: return d - a;
         15: return a - d;
         16: return d & a;
         default: return d | a;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input int addr, input logic [15:0] e);
      exp_t x;
      x.tag = tag; x.sel = sel; x.addr = addr; x.exp = e;
      sb.push_back(x);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            SelA:    check(e.tag, areg, e.exp);
            SelD:    check(e.tag, dreg, e.exp);
            SelPc:   check(e.tag, {1'b0, pc}, e.exp);
            default: check(e.tag, ram_word(e.addr), e.exp);
         endcase
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic restart();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   task automatic setw(input int i, input logic [15:0] w);
      prog[16*i +: 16] = w;
   endtask

   task automatic load_add();
      prog = '0;
      setw(0, 16'd2);
      setw(1, ci(1'b0, 6'b110000, 3'b010, 3'b000));
      setw(2, 16'd3);
      setw(3, ci(1'b0, 6'b000010, 3'b010, 3'b000));
      setw(4, 16'd0);
      setw(5, ci(1'b0, 6'b001100, 3'b001, 3'b000));
   endtask

   initial begin
      logic [15:0] dv [2];
      logic [15:0] av [2];
      logic [5:0]  jc [6];
      logic [2:0]  jj [6];
      logic [15:0] jp [6];
      dv = '{16'd1234, 16'd9};
      av = '{16'd567, 16'd32767};
      jc = '{6'b111010, 6'b101010, 6'b111111, 6'b111111, 6'b101010, 6'b111111};
      jj = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b111, 3'b000};
      jp = '{16'd10, 16'd10, 16'd10, 16'd2, 16'd10, 16'd2};

      // Add program from power-up
      load_add();
      tick(1);
      reset = 1'b0;
      tick(6);
      push("add_a", SelA, 0, 16'd0);
      push("add_d", SelD, 0, 16'd5);
      push("add_ram0", SelRam, 0, 16'd5);
      push("add_ram1", SelRam, 1, 16'd0);
      push("add_ram2", SelRam, 2, 16'd0);
      push("add_pc", SelPc, 0, 16'd6);
      drain();
      tick(2);
      push("idle_a", SelA, 0, 16'd0);
      push("idle_d", SelD, 0, 16'd5);
      push("idle_pc", SelPc, 0, 16'd8);
      drain();

      // Reload together with reset, then rerun
      mem = '0;
      mem[16*1 +: 16] = 16'h1234;
      reload = 1'b1;
      reset = 1'b1;
      tick(1);
      reload = 1'b0;
      push("rr_pc", SelPc, 0, 16'd0);
      push("rr_a", SelA, 0, 16'd0);
      push("rr_d", SelD, 0, 16'd0);
      push("rr_ram0", SelRam, 0, 16'd0);
      push("rr_ram1", SelRam, 1, 16'h1234);
      drain();
      reset = 1'b0;
      tick(6);
      push("rerun_ram0", SelRam, 0, 16'd5);
      push("rerun_d", SelD, 0, 16'd5);
      push("rerun_ram1", SelRam, 1, 16'h1234);
      drain();

      // Asynchronous reset between edges
      restart();
      tick(3);
      push("mid_pc", SelPc, 0, 16'd3);
      push("mid_a", SelA, 0, 16'd3);
      push("mid_d", SelD, 0, 16'd2);
      drain();
      #2 reset = 1'b1;
      #1;
      push("async_pc", SelPc, 0, 16'd0);
      push("async_a", SelA, 0, 16'd0);
      push("async_d", SelD, 0, 16'd0);
      push("async_ram0", SelRam, 0, 16'd5);
      drain();
      reset = 1'b0;

      // Jumps: @10 then comp;D;jump
      for (int i = 0; i < 6; i++) begin
         prog = '0;
         setw(0, 16'd10);
         setw(1, ci(1'b0, jc[i], 3'b010, jj[i]));
         restart();
         tick(2);
         push($sformatf("jump%0d_pc", i), SelPc, 0, jp[i]);
         drain();
      end

      // All 18 comp codes with the A operand
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 18; k++) begin
            prog = '0;
            setw(0, dv[p]);
            setw(1, ci(1'b0, 6'b110000, 3'b010, 3'b000));
            setw(2, av[p]);
            setw(3, ci(1'b0, codes[k], 3'b010, 3'b000));
            restart();
            tick(4);
            push($sformatf("comp%0d_p%0d", k, p), SelD, 0, ref_comp(k, dv[p], av[p]));
            drain();
         end
      end

      // AM=M+1: store uses the old A
      mem = '0;
      mem[16*7 +: 16] = 16'd3;
      prog = '0;
      setw(0, 16'd7);
      setw(1, ci(1'b1, 6'b110111, 3'b101, 3'b000));
      reload = 1'b1;
      reset = 1'b1;
      tick(1);
      reload = 1'b0;
      reset = 1'b0;
      tick(2);
      push("am_a", SelA, 0, 16'd4);
      push("am_ram7", SelRam, 7, 16'd4);
      push("am_ram4", SelRam, 4, 16'd0);
      drain();

      // M=M-1 on zero wraps to 0xFFFF
      mem[16*7 +: 16] = 16'd0;
      setw(1, ci(1'b1, 6'b110010, 3'b001, 3'b000));
      reload = 1'b1;
      reset = 1'b1;
      tick(1);
      reload = 1'b0;
      reset = 1'b0;
      tick(2);
      push("mdec_ram7", SelRam, 7, 16'hFFFF);
      push("mdec_a", SelA, 0, 16'd7);
      drain();

      // Reload wins over a store on the same edge
      mem = '0;
      mem[16*3 +: 16] = 16'h00AA;
      prog = '0;
      setw(0, 16'd3);
      setw(1, ci(1'b0, 6'b111111, 3'b001, 3'b000));
      restart();
      tick(1);
      reload = 1'b1;
      tick(1);
      reload = 1'b0;
      push("reload_wins", SelRam, 3, 16'h00AA);
      drain();

      // PC wrap from 32767
      prog = '0;
      setw(0, 16'h7FFF);
      setw(1, ci(1'b0, 6'b101010, 3'b000, 3'b111));
      setw(32767, 16'd5);
      restart();
      tick(2);
      push("wrap_top", SelPc, 0, 16'd32767);
      drain();
      tick(1);
      push("wrap_pc", SelPc, 0, 16'd0);
      push("wrap_a", SelA, 0, 16'd5);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
